// File: rtl/forward_hazard_unit_if.sv
// ID-to-hazard-unit bus for the 5-stage pipeline.
//   master : ID-stage side; drives the decoded instruction fields and flush,
//            receives stall, the EX operand forwarding selects and the stall counter.
//   slave  : forward_hazard_unit side (mirror of master).
// Fields:
//   id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread, flush
//   stall, fwd_a_sel, fwd_b_sel, stall_count
interface forward_hazard_unit_if #(
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 32
);
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic [REGW-1:0] id_rd;
  logic            id_regwrite;
  logic            id_memread;
  logic            flush;
  logic            stall;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic [CNTW-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread, flush,
    input  stall, fwd_a_sel, fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite, id_memread, flush,
    output stall, fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

// File: rtl/forward_hazard_unit.sv
// Load-use hazard detection and EX-stage operand forwarding control.
// Tracks the destination of the instructions now in EX and MEM, stalls ID for one cycle
// when it consumes the result of a load sitting in EX, and registers the 2-bit forwarding
// selects (00 regfile, 01 EX/MEM, 10 MEM/WB) for the instruction entering EX.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - forward_hazard_unit_if.slave (ID fields and flush in; stall, selects, count out)
module forward_hazard_unit #(
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 32
) (
  input logic                 clk,
  input logic                 rst,
  forward_hazard_unit_if.slave bus
);

  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelEx  = 2'b01;
  localparam logic [1:0] SelMem = 2'b10;

  // EX entry
  logic            ex_v_q, ex_v_d;
  logic [REGW-1:0] ex_rd_q, ex_rd_d;
  logic            ex_rw_q, ex_rw_d;
  logic            ex_mr_q, ex_mr_d;
  // MEM entry
  logic            mem_v_q, mem_v_d;
  logic [REGW-1:0] mem_rd_q, mem_rd_d;
  logic            mem_rw_q, mem_rw_d;
  // Outputs
  logic [1:0]      fwd_a_q, fwd_a_d;
  logic [1:0]      fwd_b_q, fwd_b_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic stall;
  logic hit_rs, hit_rt;
  logic issue;

  // The youngest result wins, and r0 is hard-wired so it is never forwarded.
  function automatic logic [1:0] sel_f(
    input logic [REGW-1:0] r,
    input logic            use_r,
    input logic            exv, input logic [REGW-1:0] exrd, input logic exrw,
    input logic            memv, input logic [REGW-1:0] memrd, input logic memrw
  );
    logic [1:0] s;
    s = SelRf;
    if (use_r && (r != '0)) begin
      if (exv && exrw && (exrd == r)) begin
        s = SelEx;
      end else if (memv && memrw && (memrd == r)) begin
        s = SelMem;
      end
    end
    return s;
  endfunction

  always_comb begin
    hit_rs = bus.id_use_rs && (bus.id_rs == ex_rd_q);
    hit_rt = bus.id_use_rt && (bus.id_rt == ex_rd_q);
    stall  = bus.id_valid && !bus.flush && ex_v_q && ex_mr_q && (ex_rd_q != '0) &&
             (hit_rs || hit_rt);
    issue  = bus.id_valid && !bus.flush && !stall;
  end

  always_comb begin
    // MEM always follows EX, independent of stall or flush.
    mem_v_d  = ex_v_q;
    mem_rd_d = ex_rd_q;
    mem_rw_d = ex_rw_q;

    ex_v_d  = 1'b0;
    ex_rd_d = ex_rd_q;
    ex_rw_d = ex_rw_q;
    ex_mr_d = ex_mr_q;
    fwd_a_d = SelRf;
    fwd_b_d = SelRf;
    if (issue) begin
      ex_v_d  = 1'b1;
      ex_rd_d = bus.id_rd;
      ex_rw_d = bus.id_regwrite;
      ex_mr_d = bus.id_memread;
      fwd_a_d = sel_f(bus.id_rs, bus.id_use_rs, ex_v_q, ex_rd_q, ex_rw_q,
                      mem_v_q, mem_rd_q, mem_rw_q);
      fwd_b_d = sel_f(bus.id_rt, bus.id_use_rt, ex_v_q, ex_rd_q, ex_rw_q,
                      mem_v_q, mem_rd_q, mem_rw_q);
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q   <= 1'b0;
      ex_rd_q  <= '0;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_rw_q <= 1'b0;
      fwd_a_q  <= SelRf;
      fwd_b_q  <= SelRf;
      cnt_q    <= '0;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= ex_rd_d;
      ex_rw_q  <= ex_rw_d;
      ex_mr_q  <= ex_mr_d;
      mem_v_q  <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      mem_rw_q <= mem_rw_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.stall_count = cnt_q;

endmodule
